// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer.
// The ROB sits between rename and retirement; DEPTH matches the free-list size.
package rob_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

   // One in-flight instruction: its destination mapping plus a completion flag.
   typedef struct packed {
      logic [5:0] A_rd;
      logic [6:0] P_rd_new;
      logic [6:0] P_rd_old;
      logic       done;
   } rob_entry_t;

   // NORMAL retires and accepts; ROLLBACK walks squashed entries back to rename.
   typedef enum logic {
      NORMAL,
      ROLLBACK
   } rob_state_e;

endpackage

// File: rtl/reorder_buffer_if.sv
// Signal bundle between the pipeline (master) and the reorder buffer (slave).
// master drives dispatch, write-back and flush; slave answers with commit,
// rollback and status.
interface reorder_buffer_if
   import rob_pkg::*;
#(
   parameter int IDX_W = ROB_IDX_W
) ();

   logic             dis_valid;
   logic             dis_ready;
   logic [5:0]       dis_A_rd;
   logic [6:0]       dis_P_rd_new;
   logic [6:0]       dis_P_rd_old;
   logic [IDX_W-1:0] dis_idx;

   logic             WB_valid;
   logic [IDX_W-1:0] WB_idx;

   logic             flush_valid;
   logic [IDX_W-1:0] flush_idx;

   logic             commit_valid;
   logic             commit_wb_en;
   logic [5:0]       commit_A_rd;
   logic [6:0]       commit_P_rd_new;
   logic [6:0]       commit_P_rd_old;

   logic             rollback_en_0;
   logic [5:0]       rollback_A_rd_0;
   logic [6:0]       rollback_P_rd_old_0;
   logic [6:0]       rollback_P_rd_new_0;
   logic             rollback_en_1;
   logic [5:0]       rollback_A_rd_1;
   logic [6:0]       rollback_P_rd_old_1;
   logic [6:0]       rollback_P_rd_new_1;

   logic             recovery;
   logic             empty;

   modport master (
      output dis_valid, dis_A_rd, dis_P_rd_new, dis_P_rd_old,
      output WB_valid, WB_idx, flush_valid, flush_idx,
      input  dis_ready, dis_idx,
      input  commit_valid, commit_wb_en, commit_A_rd, commit_P_rd_new, commit_P_rd_old,
      input  rollback_en_0, rollback_A_rd_0, rollback_P_rd_old_0, rollback_P_rd_new_0,
      input  rollback_en_1, rollback_A_rd_1, rollback_P_rd_old_1, rollback_P_rd_new_1,
      input  recovery, empty
   );

   modport slave (
      input  dis_valid, dis_A_rd, dis_P_rd_new, dis_P_rd_old,
      input  WB_valid, WB_idx, flush_valid, flush_idx,
      output dis_ready, dis_idx,
      output commit_valid, commit_wb_en, commit_A_rd, commit_P_rd_new, commit_P_rd_old,
      output rollback_en_0, rollback_A_rd_0, rollback_P_rd_old_0, rollback_P_rd_new_0,
      output rollback_en_1, rollback_A_rd_1, rollback_P_rd_old_1, rollback_P_rd_new_1,
      output recovery, empty
   );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer downstream of rename.
// Entries are allocated at tail, marked done on write-back and retired from
// head one per cycle. A mispredict walks the squashed entries youngest-first,
// two per cycle, so rename can restore its map, then pulses recovery.
// head/tail carry an extra wrap bit so full and empty are distinguishable.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input logic             clk,
   input logic             rst,
   reorder_buffer_if.slave io_rob
);

   localparam logic [IDX_W:0]   L_DEPTH   = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]   L_ONE_PTR = (IDX_W+1)'(1);
   localparam logic [IDX_W:0]   L_TWO_PTR = (IDX_W+1)'(2);
   localparam logic [IDX_W-1:0] L_ONE_IDX = IDX_W'(1);
   localparam logic [IDX_W-1:0] L_TWO_IDX = IDX_W'(2);

   rob_state_e       r_state;
   rob_state_e       w_nextState;
   logic [IDX_W:0]   r_head;
   logic [IDX_W:0]   r_tail;
   logic [IDX_W:0]   r_walkStop;
   logic             r_recovery;
   rob_entry_t       r_entry [DEPTH];

   logic [IDX_W-1:0] w_headIdx;
   logic [IDX_W-1:0] w_tailIdx;
   logic [IDX_W-1:0] w_walkIdx0;
   logic [IDX_W-1:0] w_walkIdx1;
   logic [IDX_W-1:0] w_wbOffset;
   logic [IDX_W-1:0] w_flushOffset;
   logic [IDX_W:0]   w_count;
   logic [IDX_W:0]   w_remain;
   logic [IDX_W:0]   w_walkN;
   logic [IDX_W:0]   w_walkStopNext;
   logic             w_full;
   logic             w_empty;
   logic             w_disReady;
   logic             w_dispatch;
   logic             w_flush;
   logic             w_commit;
   logic             w_wbInRange;
   logic             w_walkDone;
   logic             w_rbEn0;
   logic             w_rbEn1;
   rob_entry_t       w_headEntry;
   rob_entry_t       w_walkEntry0;
   rob_entry_t       w_walkEntry1;

   assign w_headIdx   = r_head[IDX_W-1:0];
   assign w_tailIdx   = r_tail[IDX_W-1:0];
   assign w_count     = r_tail - r_head;
   assign w_full      = (w_count == L_DEPTH);
   assign w_empty     = (r_head == r_tail);

   // Dispatch readiness deliberately ignores flush_valid so rename sees a
   // stable ready; a dispatch that collides with a flush is simply dropped.
   assign w_disReady  = (r_state == NORMAL) && !w_full;
   assign w_flush     = (r_state == NORMAL) && io_rob.flush_valid;
   assign w_dispatch  = io_rob.dis_valid && w_disReady && !io_rob.flush_valid;

   assign w_headEntry = r_entry[w_headIdx];
   assign w_commit    = (r_state == NORMAL) && !w_empty && w_headEntry.done;

   // Index distance from head tells whether a write-back targets a live entry.
   assign w_wbOffset  = io_rob.WB_idx - w_headIdx;
   assign w_wbInRange = ({1'b0, w_wbOffset} < w_count);

   // Rebuild the branch's full pointer (with wrap bit) from its index, then
   // stop the walk just past it so the branch itself survives.
   assign w_flushOffset  = io_rob.flush_idx - w_headIdx;
   assign w_walkStopNext = r_head + {1'b0, w_flushOffset} + L_ONE_PTR;

   // Entries still to be walked, and how many go out this cycle (at most two).
   assign w_remain   = r_tail - r_walkStop;
   assign w_walkDone = (w_remain <= L_TWO_PTR);
   assign w_walkN    = w_walkDone ? w_remain : L_TWO_PTR;

   assign w_walkIdx0   = w_tailIdx - L_ONE_IDX;
   assign w_walkIdx1   = w_tailIdx - L_TWO_IDX;
   assign w_walkEntry0 = r_entry[w_walkIdx0];
   assign w_walkEntry1 = r_entry[w_walkIdx1];

   // State register for the NORMAL/ROLLBACK controller.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= NORMAL;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic and rollback port enables for the walk.
   always_comb begin
      w_nextState = r_state;
      w_rbEn0     = 1'b0;
      w_rbEn1     = 1'b0;
      case (r_state)
         NORMAL: begin
            if (io_rob.flush_valid) begin
               w_nextState = ROLLBACK;
            end
         end
         ROLLBACK: begin
            w_rbEn0 = (w_remain >= L_ONE_PTR);
            w_rbEn1 = (w_remain >= L_TWO_PTR);
            if (w_walkDone) begin
               w_nextState = NORMAL;
            end
         end
         default: begin
            w_nextState = NORMAL;
         end
      endcase
   end

   // Head advances on retirement; tail grows on dispatch or shrinks during the walk.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_walkStop <= '0;
      end else begin
         if (w_commit) begin
            r_head <= r_head + L_ONE_PTR;
         end
         if (w_flush) begin
            r_walkStop <= w_walkStopNext;
         end
         if (r_state == ROLLBACK) begin
            r_tail <= r_tail - w_walkN;
         end else if (w_dispatch) begin
            r_tail <= r_tail + L_ONE_PTR;
         end
      end
   end

   // Recovery pulses for the single cycle after the last walk cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_recovery <= 1'b0;
      end else begin
         r_recovery <= (r_state == ROLLBACK) && w_walkDone;
      end
   end

   // Entry storage: new entries start not-done, write-back marks live entries done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i].done <= 1'b0;
         end
      end else begin
         if (io_rob.WB_valid && w_wbInRange) begin
            r_entry[io_rob.WB_idx].done <= 1'b1;
         end
         if (w_dispatch) begin
            r_entry[w_tailIdx] <= '{A_rd:     io_rob.dis_A_rd,
                                   P_rd_new: io_rob.dis_P_rd_new,
                                   P_rd_old: io_rob.dis_P_rd_old,
                                   done:     1'b0};
         end
      end
   end

   // Rollback ports carry the walked entries and are forced to zero when idle.
   always_comb begin
      io_rob.rollback_en_0       = w_rbEn0;
      io_rob.rollback_A_rd_0     = '0;
      io_rob.rollback_P_rd_old_0 = '0;
      io_rob.rollback_P_rd_new_0 = '0;
      io_rob.rollback_en_1       = w_rbEn1;
      io_rob.rollback_A_rd_1     = '0;
      io_rob.rollback_P_rd_old_1 = '0;
      io_rob.rollback_P_rd_new_1 = '0;
      if (w_rbEn0) begin
         io_rob.rollback_A_rd_0     = w_walkEntry0.A_rd;
         io_rob.rollback_P_rd_old_0 = w_walkEntry0.P_rd_old;
         io_rob.rollback_P_rd_new_0 = w_walkEntry0.P_rd_new;
      end
      if (w_rbEn1) begin
         io_rob.rollback_A_rd_1     = w_walkEntry1.A_rd;
         io_rob.rollback_P_rd_old_1 = w_walkEntry1.P_rd_old;
         io_rob.rollback_P_rd_new_1 = w_walkEntry1.P_rd_new;
      end
   end

   assign io_rob.dis_ready       = w_disReady;
   assign io_rob.dis_idx         = w_tailIdx;
   assign io_rob.commit_valid    = w_commit;
   assign io_rob.commit_wb_en    = w_commit && (w_headEntry.P_rd_new != 7'd0);
   assign io_rob.commit_A_rd     = w_headEntry.A_rd;
   assign io_rob.commit_P_rd_new = w_headEntry.P_rd_new;
   assign io_rob.commit_P_rd_old = w_headEntry.P_rd_old;
   assign io_rob.recovery        = r_recovery;
   assign io_rob.empty           = w_empty;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for the reorder buffer. A queue-based model of in-flight
// instructions predicts each cycle's commit, walk and status; a monitor on the
// falling edge compares the DUT against those predictions.
module tb_reorder_buffer;
   import rob_pkg::*;

   localparam int DEPTH = ROB_DEPTH;
   localparam int IDX_W = ROB_IDX_W;

   logic clk = 1'b0;
   logic rst;

   reorder_buffer_if #(.IDX_W(IDX_W)) robIf ();

   reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_rob (robIf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int aRd;
      int pNew;
      int pOld;
      bit done;
   } modelEntry_t;

   typedef struct {
      int aRd;
      int pNew;
      int pOld;
   } commitExp_t;

   typedef struct {
      bit en0;
      int a0, n0, o0;
      bit en1;
      int a1, n1, o1;
   } rollExp_t;

   modelEntry_t robQ[$];
   modelEntry_t squashQ[$];
   commitExp_t  commitQ[$];
   rollExp_t    rollQ[$];

   int tailPtr;
   bit walking;
   bit expRecovery;
   bit expReady;
   bit expEmpty;
   int expDisIdx;
   bit primed = 1'b0;

   int checks   = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Predictor: applies this cycle's inputs to the model, then predicts the next cycle.
   always @(posedge clk) begin
      bit commitNow;
      int n;
      int pos;
      commitExp_t c;
      rollExp_t   r;
      if (!rst) begin
         robQ.delete();
         squashQ.delete();
         commitQ.delete();
         rollQ.delete();
         tailPtr     = 0;
         walking     = 1'b0;
         expRecovery = 1'b0;
      end else begin
         commitNow   = !walking && robQ.size() > 0 && robQ[0].done;
         expRecovery = 1'b0;
         if (robIf.WB_valid) begin
            foreach (robQ[k]) if (robQ[k].idx == int'(robIf.WB_idx)) robQ[k].done = 1'b1;
         end
         if (walking) begin
            n = (squashQ.size() < 2) ? squashQ.size() : 2;
            for (int k = 0; k < n; k++) void'(squashQ.pop_front());
            tailPtr = (tailPtr - n + DEPTH) % DEPTH;
            if (squashQ.size() == 0) begin
               walking     = 1'b0;
               expRecovery = 1'b1;
            end
         end else if (robIf.flush_valid) begin
            pos = -1;
            foreach (robQ[k]) if (robQ[k].idx == int'(robIf.flush_idx)) pos = k;
            if (pos >= 0) begin
               while (robQ.size() > pos + 1) squashQ.push_back(robQ.pop_back());
            end
            walking = 1'b1;
         end else if (robIf.dis_valid && robQ.size() < DEPTH) begin
            robQ.push_back('{idx: tailPtr, aRd: int'(robIf.dis_A_rd), pNew: int'(robIf.dis_P_rd_new),
                             pOld: int'(robIf.dis_P_rd_old), done: 1'b0});
            tailPtr = (tailPtr + 1) % DEPTH;
         end
         if (commitNow) void'(robQ.pop_front());
      end
      expReady  = !walking && robQ.size() < DEPTH;
      expEmpty  = (robQ.size() + squashQ.size()) == 0;
      expDisIdx = tailPtr;
      if (!walking && robQ.size() > 0 && robQ[0].done) begin
         c = '{aRd: robQ[0].aRd, pNew: robQ[0].pNew, pOld: robQ[0].pOld};
         commitQ.push_back(c);
      end
      if (walking) begin
         r = '{en0: 1'b0, a0: 0, n0: 0, o0: 0, en1: 1'b0, a1: 0, n1: 0, o1: 0};
         if (squashQ.size() >= 1) begin
            r.en0 = 1'b1; r.a0 = squashQ[0].aRd; r.n0 = squashQ[0].pNew; r.o0 = squashQ[0].pOld;
         end
         if (squashQ.size() >= 2) begin
            r.en1 = 1'b1; r.a1 = squashQ[1].aRd; r.n1 = squashQ[1].pNew; r.o1 = squashQ[1].pOld;
         end
         rollQ.push_back(r);
      end
      primed = 1'b1;
   end

   // Monitor: compares what the DUT presents against the predicted responses.
   always @(negedge clk) begin
      commitExp_t c;
      rollExp_t   r;
      if (primed) begin
         checkOutput("dis_ready", int'(robIf.dis_ready), int'(expReady));
         checkOutput("empty", int'(robIf.empty), int'(expEmpty));
         checkOutput("recovery", int'(robIf.recovery), int'(expRecovery));
         checkOutput("dis_idx", int'(robIf.dis_idx), expDisIdx);
         if (commitQ.size() > 0) begin
            c = commitQ.pop_front();
            checkOutput("commit_valid", int'(robIf.commit_valid), 1);
            if (robIf.commit_valid) begin
               checkOutput("commit_A_rd", int'(robIf.commit_A_rd), c.aRd);
               checkOutput("commit_P_rd_new", int'(robIf.commit_P_rd_new), c.pNew);
               checkOutput("commit_P_rd_old", int'(robIf.commit_P_rd_old), c.pOld);
               checkOutput("commit_wb_en", int'(robIf.commit_wb_en), (c.pNew != 0) ? 1 : 0);
            end
         end else begin
            checkOutput("commit_valid_idle", int'(robIf.commit_valid), 0);
            checkOutput("commit_wb_en_idle", int'(robIf.commit_wb_en), 0);
         end
         if (rollQ.size() > 0) begin
            r = rollQ.pop_front();
         end else begin
            r = '{en0: 1'b0, a0: 0, n0: 0, o0: 0, en1: 1'b0, a1: 0, n1: 0, o1: 0};
         end
         checkOutput("rollback_en_0", int'(robIf.rollback_en_0), int'(r.en0));
         checkOutput("rollback_A_rd_0", int'(robIf.rollback_A_rd_0), r.a0);
         checkOutput("rollback_P_rd_new_0", int'(robIf.rollback_P_rd_new_0), r.n0);
         checkOutput("rollback_P_rd_old_0", int'(robIf.rollback_P_rd_old_0), r.o0);
         checkOutput("rollback_en_1", int'(robIf.rollback_en_1), int'(r.en1));
         checkOutput("rollback_A_rd_1", int'(robIf.rollback_A_rd_1), r.a1);
         checkOutput("rollback_P_rd_new_1", int'(robIf.rollback_P_rd_new_1), r.n1);
         checkOutput("rollback_P_rd_old_1", int'(robIf.rollback_P_rd_old_1), r.o1);
      end
   end

   task automatic applyStimulus(input bit dv, input int a, input int pn, input int po,
                                input bit wbv, input int wbi, input bit fv, input int fi);
      robIf.dis_valid    = dv;
      robIf.dis_A_rd     = 6'(a);
      robIf.dis_P_rd_new = 7'(pn);
      robIf.dis_P_rd_old = 7'(po);
      robIf.WB_valid     = wbv;
      robIf.WB_idx       = IDX_W'(wbi);
      robIf.flush_valid  = fv;
      robIf.flush_idx    = IDX_W'(fi);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic dispatchOne(input int a, input int pn, input int po);
      applyStimulus(1, a, pn, po, 0, 0, 0, 0);
   endtask

   task automatic wbOne(input int idx);
      applyStimulus(0, 0, 0, 0, 1, idx, 0, 0);
   endtask

   task automatic doReset(input int cycles);
      rst = 1'b0;
      idle(cycles);
      rst = 1'b1;
   endtask

   // Write back whatever is still pending until the model drains, bounded.
   task automatic drain();
      for (int cyc = 0; cyc < 80; cyc++) begin
         int pick;
         pick = -1;
         if (robQ.size() == 0 && !walking) break;
         foreach (robQ[k]) if (!robQ[k].done && pick < 0) pick = robQ[k].idx;
         if (pick >= 0) wbOne(pick);
         else idle(1);
      end
      idle(1);
      checkOutput("drain_empty", int'(robIf.empty), 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b0;
      robIf.dis_valid = 1'b0; robIf.dis_A_rd = '0; robIf.dis_P_rd_new = '0; robIf.dis_P_rd_old = '0;
      robIf.WB_valid = 1'b0; robIf.WB_idx = '0; robIf.flush_valid = 1'b0; robIf.flush_idx = '0;
      doReset(2);

      $display("[TB] out-of-order write-back, in-order commit");
      dispatchOne(1, 64, 1);
      dispatchOne(2, 65, 2);
      dispatchOne(3, 66, 3);
      wbOne(2);
      wbOne(0);
      wbOne(1);
      idle(3);
      drain();

      $display("[TB] fill to full and wrap");
      doReset(1);
      for (int i = 0; i < 17; i++) dispatchOne(i + 10, 64 + i, i);
      wbOne(0);
      idle(1);
      dispatchOne(40, 100, 41);
      drain();

      $display("[TB] six entries, flush at idx 1");
      doReset(1);
      for (int i = 0; i < 6; i++) dispatchOne(i + 1, 70 + i, 20 + i);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      idle(4);
      drain();

      $display("[TB] five entries, flush at idx 1");
      doReset(1);
      for (int i = 0; i < 5; i++) dispatchOne(i + 7, 80 + i, 30 + i);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      idle(4);
      drain();

      $display("[TB] zero-entry flush with a dispatch held");
      doReset(1);
      for (int i = 0; i < 3; i++) dispatchOne(i + 3, 90 + i, 40 + i);
      applyStimulus(1, 33, 99, 44, 0, 0, 1, 2);
      idle(3);
      drain();

      $display("[TB] no-destination commit, reset mid-walk");
      doReset(1);
      dispatchOne(5, 0, 9);
      wbOne(0);
      idle(2);
      for (int i = 0; i < 8; i++) dispatchOne(i + 20, 0 + i * 9, 50 + i);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      idle(1);
      doReset(1);
      idle(2);

      $display("[TB] randomized traffic");
      for (int cyc = 0; cyc < 600; cyc++) begin
         bit dv, wbv, fv;
         int a, pn, po, wbi, fi;
         dv  = ($urandom_range(0, 99) < 60);
         a   = $urandom_range(0, 63);
         pn  = ($urandom_range(0, 99) < 20) ? 0 : $urandom_range(1, 127);
         po  = $urandom_range(0, 127);
         wbv = 1'b0; wbi = 0;
         if (robQ.size() > 0 && $urandom_range(0, 99) < 50) begin
            wbv = 1'b1;
            wbi = robQ[$urandom_range(0, robQ.size() - 1)].idx;
         end else if ($urandom_range(0, 99) < 10) begin
            wbv = 1'b1;
            wbi = $urandom_range(0, DEPTH - 1);
         end
         fv = 1'b0; fi = 0;
         if (!walking && robQ.size() > 0 && $urandom_range(0, 99) < 5) begin
            fv = 1'b1;
            fi = robQ[$urandom_range(0, robQ.size() - 1)].idx;
         end else if (walking && $urandom_range(0, 99) < 20) begin
            fv = 1'b1;
            fi = $urandom_range(0, DEPTH - 1);
         end
         applyStimulus(dv, a, pn, po, wbv, wbi, fv, fi);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer directly downstream of the rename stage.
- Each renamed instruction is allocated an entry holding A_rd, P_rd_new and P_rd_old. Entries are marked done on write-back and retired in order. Each retirement drives the rename stage's commit port, which frees P_rd_old and updates the CMT.
- On a branch mispredict it walks squashed entries youngest-first, two per cycle, on the rename rollback ports. It then pulses recovery.

Parameters:
- DEPTH, 16, number of entries; power of two, matches free-list size.
- IDX_W, $clog2(DEPTH), entry index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; asserted when 0.
- dis_valid  in  1  renamed instruction presented.
- dis_ready  out  1  entry available and state NORMAL.
- dis_A_rd  in  6  architectural rd.
- dis_P_rd_new  in  7  new physical rd; 0 = no destination.
- dis_P_rd_old  in  7  previous mapping of A_rd.
- dis_idx  out  IDX_W  index the incoming instruction receives (= tail).
- WB_valid  in  1  completion.
- WB_idx  in  IDX_W  entry that completed.
- flush_valid  in  1  mispredicted branch resolved.
- flush_idx  in  IDX_W  branch entry; the branch survives, all younger entries are squashed.
- commit_valid  out  1  head entry retires this cycle.
- commit_wb_en  out  1  commit_valid && P_rd_new != 0.
- commit_A_rd  out  6  head entry field.
- commit_P_rd_new  out  7  head entry field.
- commit_P_rd_old  out  7  head entry field.
- rollback_en_0  out  1  youngest entry walked this cycle.
- rollback_A_rd_0  out  6  fields of that entry.
- rollback_P_rd_old_0  out  7  fields of that entry.
- rollback_P_rd_new_0  out  7  fields of that entry.
- rollback_en_1  out  1  next-older entry walked this cycle.
- rollback_A_rd_1  out  6  fields of that entry.
- rollback_P_rd_old_1  out  7  fields of that entry.
- rollback_P_rd_new_1  out  7  fields of that entry.
- recovery  out  1  one-cycle pulse when the walk finishes.
- empty  out  1  no valid entries.

Behaviour:
- Pointers:
  - head and tail are IDX_W+1 bits wide (wrap bit); index = low bits.
  - count = tail - head.
  - full when count == DEPTH; empty when equal.
- Reset (rst==0 at posedge):
  - head = tail = 0, all done bits cleared, state NORMAL.
  - All registered outputs 0; dis_ready = 1; empty = 1.
- dis_ready = (state==NORMAL) && !full. It is combinational and independent of flush_valid.
- Dispatch (dis_valid && dis_ready):
  - Write the entry at tail with done=0; tail+1 at the next edge.
  - dis_idx is valid in the same cycle.
- Write-back: WB_valid sets done[WB_idx] at the next edge. Indices outside [head, tail) are ignored.
- Commit:
  - Outputs are combinational from the head entry: commit_valid = state==NORMAL && !empty && done[head].
  - head+1 at the edge. At most one commit per cycle.
  - A non-rd entry (P_rd_new==0) commits with commit_wb_en=0.
- States NORMAL, ROLLBACK.
- NORMAL + flush_valid:
  - walk_stop = flush_idx+1 (with wrap bit); state -> ROLLBACK.
  - A dispatch in the same cycle is discarded; tail does not advance.
  - A commit in the same cycle still occurs.
- ROLLBACK, each cycle:
  - n = min(2, tail - walk_stop).
  - Port 0 carries entry tail-1 when n>=1; port 1 carries tail-2 when n==2.
  - tail -= n.
  - When tail - walk_stop <= 2 this cycle, next state is NORMAL and recovery=1 for exactly that next cycle. Dispatch resumes in that cycle.
- Zero-entry flush (flush_idx == tail-1): ROLLBACK lasts one cycle with no rollback_en, then recovery pulses.
- Port order: port 1 is older, because rename gives port 1 priority on an A_rd collision; restoring the older P_rd_old is correct.
- Squashed entries with P_rd_new==0 are still walked, with P_rd_new=0 on the port.
- During ROLLBACK: flush_valid is ignored; commit and dispatch are stalled; WB_valid still updates done.
- All rollback_* outputs are 0 whenever their en is 0.

Decomposition:
- Package rob_pkg:
  - ROB_DEPTH and ROB_IDX_W constants.
  - rob_entry_t struct: A_rd[5:0], P_rd_new[6:0], P_rd_old[6:0], done.
  - rob_state_e enum {NORMAL, ROLLBACK}.
- No sub-module. Entry storage is a flop array inside the block; the walk and commit selects are plain muxes.

Test Plan:
- Reset, then dispatch 3 entries (A_rd 1/2/3, P_new 64/65/66, P_old 1/2/3) and WB them out of order (2, 0, 1). Required: commits in idx order 0, 1, 2 on the 3rd WB cycle and the following two; commit_P_rd_old = 1, 2, 3.
- Fill 16 entries with no WB. Required: dis_ready=0 at count 16. Then WB idx 0: one commit, and dis_ready=1 the next cycle; tail wraps to 0 with the wrap bit set.
- 6 entries (idx 0..5), flush_idx=1. Required:
  - cycle 1: ports show idx 5/4;
  - cycle 2: idx 3/2;
  - then recovery=1; tail=2; idx 1 stays uncommitted until its WB.
- 5 entries, flush_idx=1. Required: walk 4/3, then 2 alone (rollback_en_1=0), then recovery.
- Flush with flush_idx = tail-1. Required: no rollback_en, recovery pulses 2 cycles after flush; a dispatch held during the flush cycle is dropped.
- Entry with P_rd_new=0 at head done. Required: commit_valid=1, commit_wb_en=0. rst=0 asserted mid-ROLLBACK: next cycle empty=1, recovery=0, all rollback_en=0.
